// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared FSM types and sync marker constants for the serial pattern transmitter/detectors
package fsm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } tx_state_t;

   localparam logic [2:0] SYNC_PATTERN = 3'b101;
   localparam int         SYNC_LEN     = 3;

   // The shared down-counter only ever holds (length - 1) of the longest state.
   function automatic int cnt_width(input int data_w, input int gap_cycles);
      int m;
      m = data_w;
      if (gap_cycles > m) m = gap_cycles;
      if (SYNC_LEN > m)   m = SYNC_LEN;
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial frame transmitter with idle gap
// Optional "101" sync marker ahead of each payload when SEQ_SYNC_HDR_EN is defined.
module seq_pattern_tx
   import fsm_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              x,
   output logic              x_valid,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = cnt_width(DATA_W, GAP_CYCLES);
   localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef SEQ_SYNC_HDR_EN
   localparam logic [CNT_W-1:0] C_SYNC_LAST = CNT_W'(SYNC_LEN - 1);
`endif

   tx_state_t         r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_x;
   logic              r_x_valid;
   logic              r_done;

   // r_x/r_x_valid are loaded with the value for the cycle that follows each edge,
   // so the line stays registered while the first bit appears right after the accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_x       <= 1'b0;
         r_x_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x_valid <= 1'b1;
`ifdef SEQ_SYNC_HDR_EN
                  r_state   <= SYNC;
                  r_shift   <= in_data;
                  r_cnt     <= C_SYNC_LAST;
                  r_x       <= SYNC_PATTERN[2];
`else
                  r_state   <= DATA;
                  r_shift   <= in_data << 1;
                  r_cnt     <= C_DATA_LAST;
                  r_x       <= in_data[DATA_W-1];
`endif
               end
            end
`ifdef SEQ_SYNC_HDR_EN
            SYNC: begin
               if (r_cnt == '0) begin
                  r_state <= DATA;
                  r_cnt   <= C_DATA_LAST;
                  r_x     <= r_shift[DATA_W-1];
                  r_shift <= r_shift << 1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
                  r_x   <= (r_cnt == CNT_W'(1)) ? SYNC_PATTERN[0] : SYNC_PATTERN[1];
               end
            end
`endif
            DATA: begin
               if (r_cnt == '0) begin
                  r_x       <= 1'b0;
                  r_x_valid <= 1'b0;
                  r_done    <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     r_state <= GAP;
                     r_cnt   <= C_GAP_LAST;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt   <= r_cnt - 1'b1;
                  r_x     <= r_shift[DATA_W-1];
                  r_shift <= r_shift << 1;
               end
            end
            GAP: begin
               if (r_cnt == '0) r_state <= IDLE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign x        = r_x;
   assign x_valid  = r_x_valid;
   assign done     = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed/randomized bench for seq_pattern_tx against a frame-level model
module tb_seq_pattern_tx;

   localparam int W = 8;
   localparam int G = 2;
`ifdef SEQ_SYNC_HDR_EN
   localparam int HDR = 3;
`else
   localparam int HDR = 0;
`endif
   localparam int L = HDR + W;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready, x, x_valid, busy, done;

   logic         in_valid1 = 1'b0;
   logic [0:0]   in_data1 = '0;
   logic         in_ready1, x1, x_valid1, busy1, done1;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   seq_pattern_tx #(.DATA_W(W), .GAP_CYCLES(G)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
   );

   seq_pattern_tx #(.DATA_W(1), .GAP_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .x(x1), .x_valid(x_valid1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame position p: marker "101" first (if enabled), then payload MSB first.
   function automatic logic exp_bit(input logic [W-1:0] d, input int p);
      if (p < HDR) return (p == 1) ? 1'b0 : 1'b1;
      return d[W-1-(p-HDR)];
   endfunction

   // Call at a negedge with the DUT idle; returns at the negedge of the first idle cycle after the gap.
   task automatic do_frame(input logic [W-1:0] d, input bit keep_valid, input string tag);
      check($sformatf("%s.rdy_start", tag), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      for (int c = 1; c <= L + G + 1; c++) begin
         @(negedge clk);
         in_valid = keep_valid;
         in_data  = W'($urandom);
         if (c <= L) begin
            check($sformatf("%s.c%0d.xv", tag, c), 32'(x_valid), 32'd1);
            check($sformatf("%s.c%0d.x", tag, c), 32'(x), 32'(exp_bit(d, c - 1)));
            check($sformatf("%s.c%0d.rdy", tag, c), 32'(in_ready), 32'd0);
            check($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'd1);
            check($sformatf("%s.c%0d.done", tag, c), 32'(done), 32'd0);
         end else begin
            check($sformatf("%s.c%0d.xv", tag, c), 32'(x_valid), 32'd0);
            check($sformatf("%s.c%0d.x", tag, c), 32'(x), 32'd0);
            check($sformatf("%s.c%0d.done", tag, c), 32'(done), 32'(c == L + 1));
            check($sformatf("%s.c%0d.rdy", tag, c), 32'(in_ready), 32'(c == L + G + 1));
            check($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'(c != L + G + 1));
         end
      end
   endtask

   initial begin
      bit keep;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle.rdy", 32'(in_ready), 32'd1);
         check("idle.x", 32'(x), 32'd0);
         check("idle.xv", 32'(x_valid), 32'd0);
         check("idle.busy", 32'(busy), 32'd0);
         check("idle.done", 32'(done), 32'd0);
      end

      do_frame(8'hA5, 1'b0, "a5");
      do_frame(8'h00, 1'b0, "zero");
      do_frame(8'hFF, 1'b1, "ff_b2b");
      do_frame(8'h81, 1'b0, "81_b2b");

      // reset during the 4th payload bit of 8'hF0
      in_valid = 1'b1;
      in_data  = 8'hF0;
      for (int c = 1; c <= HDR + 4; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      check("rst.pre_x", 32'(x), 32'd1);
      check("rst.pre_xv", 32'(x_valid), 32'd1);
      #1 reset = 1'b1;
      in_valid = 1'b1;
      #1;
      check("rst.async_x", 32'(x), 32'd0);
      check("rst.async_xv", 32'(x_valid), 32'd0);
      check("rst.async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rst.held_xv", 32'(x_valid), 32'd0);
      reset    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst.after_rdy", 32'(in_ready), 32'd1);
         check("rst.after_done", 32'(done), 32'd0);
         check("rst.after_xv", 32'(x_valid), 32'd0);
      end
      do_frame(8'h3C, 1'b0, "post_rst");

      keep = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
         keep = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         do_frame(W'($urandom), keep, $sformatf("rnd%0d", i));
      end
      in_valid = 1'b0;

      // DATA_W=1, GAP_CYCLES=0 instance
      @(negedge clk);
      in_valid1 = 1'b1;
      in_data1  = 1'b1;
      for (int c = 1; c <= HDR + 2; c++) begin
         @(negedge clk);
         in_valid1 = 1'b0;
         if (c <= HDR + 1) begin
            check($sformatf("w1.c%0d.xv", c), 32'(x_valid1), 32'd1);
            check($sformatf("w1.c%0d.x", c), 32'(x1), 32'((c - 1 < HDR) ? (c != 2) : 1));
            check($sformatf("w1.c%0d.done", c), 32'(done1), 32'd0);
            check($sformatf("w1.c%0d.rdy", c), 32'(in_ready1), 32'd0);
         end else begin
            check("w1.end.xv", 32'(x_valid1), 32'd0);
            check("w1.end.done", 32'(done1), 32'd1);
            check("w1.end.rdy", 32'(in_ready1), 32'd1);
         end
      end
      @(negedge clk);
      check("w1.done_once", 32'(done1), 32'd0);
      check("w1.busy_idle", 32'(busy1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
